// File: rtl/xif_result_rob.sv
// In-order result buffer between FPU lanes and the CORE-V-XIF result interface.
// Entries are allocated at issue, completed out of order, and emitted in issue order once committed.
module xif_result_rob #(
  parameter int DEPTH      = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5,
  parameter int NUM_LANES  = 2
) (
  input  logic                            ck,
  input  logic                            rst,
  input  logic                            alloc_valid,
  output logic                            alloc_ready,
  input  logic [ID_WIDTH-1:0]             alloc_id,
  input  logic [RD_WIDTH-1:0]             alloc_rd,
  input  logic                            commit_valid,
  input  logic [ID_WIDTH-1:0]             commit_id,
  input  logic                            commit_kill,
  input  logic [NUM_LANES-1:0]            cmpl_valid,
  input  logic [NUM_LANES*ID_WIDTH-1:0]   cmpl_id,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] cmpl_data,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic [ID_WIDTH-1:0]             result_id,
  output logic [DATA_WIDTH-1:0]           result_data,
  output logic [RD_WIDTH-1:0]             result_rd,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]      ent_valid, ent_done, ent_cmt, ent_kill;
  logic [ID_WIDTH-1:0]   ent_id   [DEPTH];
  logic [RD_WIDTH-1:0]   ent_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [PW-1:0]         head, tail;

  logic                  full, do_alloc;
  logic [DEPTH-1:0]      cmt_hit, cpl_set;
  logic [DEPTH-1:0]      lane_hit [NUM_LANES];
  logic [DATA_WIDTH-1:0] cpl_data [DEPTH];
  logic                  err_now;
  logic                  head_elig, out_free, retire, load;

  assign full        = (count == CW'(DEPTH));
  assign alloc_ready = !full;
  assign do_alloc    = alloc_valid && !full;

  // Associative lookup against registered entries; an entry allocated this cycle is not yet visible.
  always_comb begin
    cmt_hit  = '0;
    cpl_set  = '0;
    lane_hit = '{default: '0};
    cpl_data = '{default: '0};
    err_now  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cmt_hit[i] = commit_valid && ent_valid[i] && (ent_id[i] == commit_id);
    end
    if (commit_valid && (cmt_hit == '0)) err_now = 1'b1;
    // Ascending lane order lets the lowest-indexed lane claim an entry first.
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int i = 0; i < DEPTH; i++) begin
        lane_hit[l][i] = cmpl_valid[l] && ent_valid[i] &&
                         (ent_id[i] == cmpl_id[l*ID_WIDTH +: ID_WIDTH]);
      end
      if (cmpl_valid[l] && (lane_hit[l] == '0)) err_now = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (lane_hit[l][i]) begin
          if (ent_done[i] || cpl_set[i]) begin
            err_now = 1'b1;
          end else begin
            cpl_set[i]  = 1'b1;
            cpl_data[i] = cmpl_data[l*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Killed heads still wait for done so a late completion cannot hit a reused id.
  assign head_elig = ent_valid[head] && ent_done[head] && ent_cmt[head];
  assign out_free  = !result_valid || result_ready;
  assign retire    = head_elig && (ent_kill[head] || out_free);
  assign load      = head_elig && !ent_kill[head] && out_free;

  always_ff @(posedge ck) begin
    if (rst) begin
      ent_valid    <= '0;
      ent_done     <= '0;
      ent_cmt      <= '0;
      ent_kill     <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      proto_err    <= 1'b0;
      result_valid <= 1'b0;
      result_id    <= '0;
      result_data  <= '0;
      result_rd    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cmt_hit[i]) begin
          ent_cmt[i]  <= 1'b1;
          ent_kill[i] <= commit_kill;
        end
        if (cpl_set[i]) ent_done[i] <= 1'b1;
      end
      if (do_alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        ent_cmt[tail]   <= 1'b0;
        ent_kill[tail]  <= 1'b0;
        tail            <= tail + 1'b1;
      end
      if (retire) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      count <= count + CW'(do_alloc) - CW'(retire);
      if ((alloc_valid && full) || err_now) proto_err <= 1'b1;
      if (load) begin
        result_valid <= 1'b1;
        result_id    <= ent_id[head];
        result_data  <= ent_data[head];
        result_rd    <= ent_rd[head];
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

  // Payload storage carries no reset; ent_valid qualifies every use.
  always_ff @(posedge ck) begin
    if (do_alloc) begin
      ent_id[tail] <= alloc_id;
      ent_rd[tail] <= alloc_rd;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (cpl_set[i]) ent_data[i] <= cpl_data[i];
    end
  end

endmodule

// File: tb/tb_xif_result_rob.sv
// Bench for xif_result_rob: queue-based in-flight model with a result scoreboard,
// directed scenarios followed by randomized traffic.
module tb_xif_result_rob;
  localparam int DEPTH = 8;
  localparam int IDW   = 4;
  localparam int DW    = 32;
  localparam int RDW   = 5;
  localparam int NL    = 2;

  logic              ck = 1'b0;
  logic              rst;
  logic              alloc_valid, alloc_ready;
  logic [IDW-1:0]    alloc_id;
  logic [RDW-1:0]    alloc_rd;
  logic              commit_valid, commit_kill;
  logic [IDW-1:0]    commit_id;
  logic [NL-1:0]     cmpl_valid;
  logic [NL*IDW-1:0] cmpl_id;
  logic [NL*DW-1:0]  cmpl_data;
  logic              result_valid, result_ready;
  logic [IDW-1:0]    result_id;
  logic [DW-1:0]     result_data;
  logic [RDW-1:0]    result_rd;
  logic [$clog2(DEPTH):0] count;
  logic              proto_err;

  always #5 ck = ~ck;

  xif_result_rob #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .RD_WIDTH(RDW), .NUM_LANES(NL)) dut (
    .ck(ck), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id), .alloc_rd(alloc_rd),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id), .cmpl_data(cmpl_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data), .result_rd(result_rd), .count(count), .proto_err(proto_err)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [RDW-1:0] rd;
    logic [DW-1:0]  data;
    bit done;
    bit cmt;
    bit kil;
  } ent_t;

  ent_t q[$];
  ent_t snap[$];
  ent_t exp_q[$];
  ent_t out_e;
  ent_t m_e;
  bit   out_v;
  bit   perr;
  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  logic [DW-1:0] last_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int find_id(input logic [IDW-1:0] id);
    for (int i = 0; i < snap.size(); i++) if (snap[i].id == id) return i;
    return -1;
  endfunction

  function automatic bit in_flight(input logic [IDW-1:0] id);
    foreach (q[i]) if (q[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: in-flight instructions kept in program order; the head leaves when done and committed.
  task automatic model_step();
    bit ret, ld;
    int idx;
    bit tk[DEPTH];
    if (rst) begin
      q.delete(); exp_q.delete();
      out_v = 0; perr = 0;
      return;
    end
    snap = q;
    ret = 0; ld = 0;
    foreach (tk[i]) tk[i] = 0;
    if (snap.size() > 0 && snap[0].done && snap[0].cmt) begin
      if (snap[0].kil) ret = 1;
      else if (!out_v || result_ready) begin ret = 1; ld = 1; end
    end
    if (commit_valid) begin
      idx = find_id(commit_id);
      if (idx < 0) perr = 1;
      else begin q[idx].cmt = 1; q[idx].kil = commit_kill; end
    end
    for (int l = 0; l < NL; l++) begin
      if (cmpl_valid[l]) begin
        idx = find_id(cmpl_id[l*IDW +: IDW]);
        if (idx < 0) perr = 1;
        else if (snap[idx].done || tk[idx]) perr = 1;
        else begin
          q[idx].done = 1;
          q[idx].data = cmpl_data[l*DW +: DW];
          tk[idx] = 1;
        end
      end
    end
    if (alloc_valid) begin
      if (snap.size() < DEPTH) q.push_back('{alloc_id, alloc_rd, '0, 0, 0, 0});
      else perr = 1;
    end
    if (ld) begin
      out_e = snap[0];
      out_v = 1;
      exp_q.push_back(snap[0]);
    end else if (out_v && result_ready) begin
      out_v = 0;
    end
    if (ret) void'(q.pop_front());
  endtask

  task automatic check_state();
    chk("result_valid", 64'(result_valid), 64'(out_v));
    if (out_v) begin
      chk("result_id", 64'(result_id), 64'(out_e.id));
      chk("result_data", 64'(result_data), 64'(out_e.data));
      chk("result_rd", 64'(result_rd), 64'(out_e.rd));
    end
    chk("count", 64'(count), 64'(q.size()));
    chk("alloc_ready", 64'(alloc_ready), 64'(q.size() < DEPTH));
    chk("proto_err", 64'(proto_err), 64'(perr));
  endtask

  task automatic step();
    model_step();
    @(posedge ck);
    #1;
    check_state();
  endtask

  task automatic idle();
    rst = 0; alloc_valid = 0; alloc_id = '0; alloc_rd = '0;
    commit_valid = 0; commit_id = '0; commit_kill = 0;
    cmpl_valid = '0; cmpl_id = '0; cmpl_data = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic do_alloc(input int id, input int rd);
    idle(); alloc_valid = 1; alloc_id = IDW'(id); alloc_rd = RDW'(rd); step();
  endtask

  task automatic do_commit(input int id, input bit kill);
    idle(); commit_valid = 1; commit_id = IDW'(id); commit_kill = kill; step();
  endtask

  task automatic set_lane(input int l, input int id, input logic [DW-1:0] d);
    cmpl_valid[l] = 1'b1;
    cmpl_id[l*IDW +: IDW] = IDW'(id);
    cmpl_data[l*DW +: DW] = d;
  endtask

  task automatic do_cmpl(input int l, input int id, input logic [DW-1:0] d);
    idle(); set_lane(l, id, d); step();
  endtask

  task automatic run(input int n);
    idle();
    repeat (n) step();
  endtask

  // Scoreboard monitor: a handshake seen here completes at the next rising edge.
  always @(negedge ck) begin
    if (!rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result actual_id=%0h required=none", result_id);
      end else begin
        m_e = exp_q.pop_front();
        chk("sb_id", 64'(result_id), 64'(m_e.id));
        chk("sb_data", 64'(result_data), 64'(m_e.data));
        chk("sb_rd", 64'(result_rd), 64'(m_e.rd));
        last_data = result_data;
        n_out++;
      end
    end
  end

  initial begin
    int n0, c0, r, pick;
    int cand[$];
    bit err_mode;
    idle();
    result_ready = 1;
    out_v = 0; perr = 0;
    do_reset();
    chk("rst_result_id", 64'(result_id), 64'd0);
    chk("rst_result_data", 64'(result_data), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);

    // In-order emission despite out-of-order completion
    n0 = n_out;
    do_alloc(1, 4); do_alloc(2, 5); do_alloc(3, 6);
    do_cmpl(0, 3, 32'hC); do_cmpl(0, 1, 32'hA); do_cmpl(0, 2, 32'hB);
    do_commit(1, 0); do_commit(2, 0); do_commit(3, 0);
    run(5);
    chk("t1_results", 64'(n_out - n0), 64'd3);
    chk("t1_count", 64'(count), 64'd0);

    // Full buffer and overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_alloc(i, i);
    chk("t2_full_ready", 64'(alloc_ready), 64'd0);
    chk("t2_full_count", 64'(count), 64'd8);
    do_alloc(9, 9);
    chk("t2_overflow_err", 64'(proto_err), 64'd1);
    idle(); set_lane(0, 0, 32'h55); commit_valid = 1; commit_id = '0; step();
    run(1);
    chk("t2_ready_after_retire", 64'(alloc_ready), 64'd1);

    // Killed entry retires silently
    do_reset();
    n0 = n_out;
    do_alloc(5, 1); do_alloc(6, 2);
    do_commit(5, 1);
    idle(); set_lane(0, 5, 32'h50); set_lane(1, 6, 32'h60); step();
    do_commit(6, 0);
    run(4);
    chk("t3_results", 64'(n_out - n0), 64'd1);
    chk("t3_last_data", 64'(last_data), 64'h60);

    // Back-pressure holds the output
    do_reset();
    result_ready = 0;
    n0 = n_out;
    do_alloc(1, 7); do_alloc(2, 8); do_alloc(3, 9);
    idle(); set_lane(0, 1, 32'h111); set_lane(1, 2, 32'h222); step();
    do_cmpl(0, 3, 32'h333);
    do_commit(1, 0); do_commit(2, 0); do_commit(3, 0);
    c0 = count;
    run(4);
    chk("t4_count_held", 64'(count), 64'(c0));
    chk("t4_id_held", 64'(result_id), 64'd1);
    result_ready = 1;
    run(4);
    chk("t4_results", 64'(n_out - n0), 64'd3);

    // Two lanes on one entry, then an unknown id
    do_reset();
    do_alloc(7, 3);
    idle(); set_lane(0, 7, 32'h11); set_lane(1, 7, 32'h22); step();
    chk("t5_dual_err", 64'(proto_err), 64'd1);
    do_commit(7, 0);
    run(3);
    chk("t5_data", 64'(last_data), 64'h11);
    do_cmpl(0, 15, 32'h99);
    run(1);

    // Reset with entries in flight and a pending output
    do_reset();
    result_ready = 0;
    for (int i = 1; i <= 4; i++) do_alloc(i, i);
    do_cmpl(0, 1, 32'hAB);
    do_commit(1, 0);
    do_cmpl(0, 15, 32'h0);
    run(2);
    chk("t6_pre_valid", 64'(result_valid), 64'd1);
    do_reset();
    chk("t6_valid", 64'(result_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_ready", 64'(alloc_ready), 64'd1);
    chk("t6_err", 64'(proto_err), 64'd0);
    result_ready = 1;
    run(3);

    // Randomized traffic: clean first, then with protocol errors mixed in
    do_reset();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      err_mode = (cyc >= 1500);
      if (cyc == 2000) begin
        do_reset();
        continue;
      end
      idle();
      result_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1 && (err_mode || q.size() < DEPTH)) begin
        alloc_valid = 1;
        do r = $urandom_range(0, 15); while (in_flight(IDW'(r)));
        alloc_id = IDW'(r);
        alloc_rd = RDW'($urandom);
      end
      cand.delete();
      foreach (q[i]) if (!q[i].cmt) cand.push_back(i);
      if (err_mode && $urandom_range(0, 9) == 0) begin
        commit_valid = 1; commit_id = IDW'($urandom_range(0, 15));
      end else if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
        commit_valid = 1;
        commit_id = q[cand[$urandom_range(0, cand.size() - 1)]].id;
        commit_kill = ($urandom_range(0, 3) == 0);
      end
      pick = -1;
      for (int l = 0; l < NL; l++) begin
        cand.delete();
        foreach (q[i]) if (!q[i].done && i != pick) cand.push_back(i);
        if (err_mode && $urandom_range(0, 9) == 0) begin
          set_lane(l, $urandom_range(0, 15), $urandom);
        end else if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
          pick = cand[$urandom_range(0, cand.size() - 1)];
          set_lane(l, q[pick].id, $urandom);
        end
      end
      step();
    end
    result_ready = 1;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
